// File: rtl/program_loader.sv
// Framed byte-stream bootloader: parses MAGIC/length/payload/checksum frames,
// writes the payload into program memory and releases the CPU on a good image.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MEM_BYTES      = 1024,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  MAGIC          = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] write_address,
  output logic [7:0]  write_data,
  output logic        write_enable,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0]       MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [31:0]       byte_cnt;
  logic [31:0]       length;
  logic [7:0]        checksum;
  logic [IDLE_W-1:0] idle_cnt;

  logic        xfer;
  logic        is_magic;
  logic        in_frame;
  logic        timed_out;
  logic [31:0] len_next;

  assign xfer      = rx_valid && rx_ready;
  assign is_magic  = xfer && (rx_data == MAGIC);
  assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign timed_out = in_frame && !xfer && (idle_cnt == IDLE_LAST);
  // Length arrives LSB first, so each new byte shifts in from the top.
  assign len_next  = {rx_data, length[31:8]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rx_ready      <= 1'b0;
      write_address <= BASE_ADDR;
      write_data    <= '0;
      write_enable  <= 1'b0;
      cpu_reset_n   <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      byte_cnt      <= '0;
      length        <= '0;
      checksum      <= '0;
      idle_cnt      <= '0;
    end else begin
      rx_ready     <= 1'b1;
      write_enable <= 1'b0;

      if (in_frame && !xfer) idle_cnt <= idle_cnt + IDLE_W'(1);
      else                   idle_cnt <= '0;

      case (state)
        S_IDLE: begin
          cpu_reset_n <= 1'b0;
          load_done   <= 1'b0;
          load_error  <= 1'b0;
          if (is_magic) begin
            state    <= S_LEN;
            byte_cnt <= '0;
            length   <= '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            length        <= len_next;
            checksum      <= '0;
            write_address <= BASE_ADDR;
            if (byte_cnt == 32'd3) begin
              byte_cnt <= '0;
              if (len_next > MEM_LIMIT) state <= S_ERROR;
              else if (len_next == '0)  state <= S_CHK;
              else                      state <= S_DATA;
            end else begin
              byte_cnt <= byte_cnt + 32'd1;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            write_enable  <= 1'b1;
            write_data    <= rx_data;
            write_address <= BASE_ADDR + byte_cnt;
            checksum      <= checksum + rx_data;
            if (byte_cnt == length - 32'd1) state <= S_CHK;
            else                            byte_cnt <= byte_cnt + 32'd1;
          end
        end
        S_CHK: begin
          if (xfer) state <= (rx_data == checksum) ? S_DONE : S_ERROR;
        end
        S_DONE: begin
          if (is_magic) begin
            cpu_reset_n <= 1'b0;
            load_done   <= 1'b0;
            state       <= S_LEN;
            byte_cnt    <= '0;
            length      <= '0;
          end else begin
            cpu_reset_n <= 1'b1;
            load_done   <= 1'b1;
          end
        end
        S_ERROR: begin
          cpu_reset_n <= 1'b0;
          if (is_magic) begin
            load_error <= 1'b0;
            state      <= S_LEN;
            byte_cnt   <= '0;
            length     <= '0;
          end else begin
            load_error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // An inter-byte gap that is too long abandons the frame.
      if (timed_out) state <= S_ERROR;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level parser model.
`timescale 1ns/1ps
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MEMB = 1024;
  localparam int          TO   = 16;
  localparam logic [7:0]  MG   = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] write_address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  program_loader #(
    .BASE_ADDR(BASE), .MEM_BYTES(MEMB), .TIMEOUT_CYCLES(TO), .MAGIC(MG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .cpu_reset_n(cpu_reset_n),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] b; int hs; } tx_t;
  typedef struct { int c; logic [31:0] a; logic [7:0] d; } wr_t;

  tx_t        sent[$];
  wr_t        obs[$];
  wr_t        expw[$];
  logic [7:0] bq[$];
  logic [7:0] pay[$];
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  always @(negedge clk)
    if (write_enable === 1'b1) obs.push_back('{cyc, write_address, write_data});

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Called just after a rising edge; the byte is accepted at the next edge.
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    sent.push_back('{b, cyc});
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bytes();
    foreach (bq[k]) drive(bq[k]);
  endtask

  task automatic send_frame(input int len, input logic [7:0] ck_xor, input int gmax);
    logic [7:0] s;
    s = 8'h00;
    drive(MG);
    for (int k = 0; k < 4; k++) begin
      idle($urandom_range(0, gmax));
      drive(8'(len >> (8 * k)));
    end
    for (int k = 0; k < len; k++) begin
      idle($urandom_range(0, gmax));
      drive(pay[k]);
      s = s + pay[k];
    end
    idle($urandom_range(0, gmax));
    drive(s ^ ck_xor);
  endtask

  function automatic bit gap_bad(input int j);
    if (j >= sent.size()) return 1'b1;
    return (sent[j].hs - sent[j-1].hs - 1) >= TO;
  endfunction

  // Frame-level parser over the accepted byte history.
  task automatic run_model();
    int i, j, n, nxt;
    int unsigned len;
    logic [7:0] sum;
    bit fail;
    n = sent.size();
    i = 0;
    expw.delete();
    while (i < n) begin
      if (sent[i].b != MG) begin i++; continue; end
      m_done = 1'b0; m_err = 1'b0;
      fail = 1'b0; len = 0; sum = 8'h00; j = i; nxt = n;
      for (int k = 0; k < 4 && !fail; k++) begin
        j++;
        if (gap_bad(j)) begin fail = 1'b1; nxt = j; end
        else len = len | (32'(sent[j].b) << (8 * k));
      end
      if (!fail && len > MEMB) begin fail = 1'b1; nxt = j + 1; end
      for (int unsigned p = 0; p < len && !fail; p++) begin
        j++;
        if (gap_bad(j)) begin fail = 1'b1; nxt = j; end
        else begin
          expw.push_back('{sent[j].hs + 1, BASE + p, sent[j].b});
          sum = sum + sent[j].b;
        end
      end
      if (!fail) begin
        j++;
        if (gap_bad(j)) begin fail = 1'b1; nxt = j; end
        else begin
          nxt = j + 1;
          if (sent[j].b != sum) fail = 1'b1;
        end
      end
      m_err  = fail;
      m_done = !fail;
      i = nxt;
    end
  endtask

  task automatic check_segment(input string tag);
    idle(TO + 8);
    run_model();
    chk({tag, ".nwr"}, 96'(obs.size()), 96'(expw.size()));
    for (int k = 0; k < expw.size() && k < obs.size(); k++)
      chk({tag, ".wr"}, {32'(obs[k].c), obs[k].a, obs[k].d},
          {32'(expw[k].c), expw[k].a, expw[k].d});
    chk({tag, ".load_done"},   96'(load_done),   96'(m_done));
    chk({tag, ".cpu_reset_n"}, 96'(cpu_reset_n), 96'(m_done));
    chk({tag, ".load_error"},  96'(load_error),  96'(m_err));
    chk({tag, ".rx_ready"},    96'(rx_ready),    96'(1));
    sent.delete();
    obs.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".rx_ready"},      96'(rx_ready),      96'(0));
    chk({tag, ".write_address"}, 96'(write_address), 96'(BASE));
    chk({tag, ".write_data"},    96'(write_data),    96'(0));
    chk({tag, ".write_enable"},  96'(write_enable),  96'(0));
    chk({tag, ".cpu_reset_n"},   96'(cpu_reset_n),   96'(0));
    chk({tag, ".load_done"},     96'(load_done),     96'(0));
    chk({tag, ".load_error"},    96'(load_error),    96'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    logic [7:0] g;

    // Power-on reset
    reset_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    sent.delete(); obs.delete();

    // Basic 4-byte frame, plus DONE timing relative to the checksum handshake
    bq = '{MG, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_bytes();
    hc = cyc;
    drive(8'h13);
    @(negedge clk);
    chk("done_t1.load_done",   96'(load_done),   96'(0));
    chk("done_t1.cpu_reset_n", 96'(cpu_reset_n), 96'(0));
    chk("done_t1.cycle",       96'(cyc),         96'(hc + 1));
    @(negedge clk);
    chk("done_t2.load_done",   96'(load_done),   96'(1));
    chk("done_t2.cpu_reset_n", 96'(cpu_reset_n), 96'(1));
    @(posedge clk); #1;
    check_segment("frame4");

    // Bad checksum, then recovery
    bq = '{MG, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
    send_bytes();
    check_segment("badck");
    send_bytes();
    bq[9] = 8'h13;
    bq = '{MG, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02, 8'h42};
    send_bytes();
    check_segment("recover");

    // Oversize length, trailing bytes must not write
    bq = '{MG, 8'h01, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send_bytes();
    check_segment("oversize");

    // Exactly MEM_BYTES payload
    pay.delete();
    for (int k = 0; k < MEMB; k++) pay.push_back(8'($urandom));
    send_frame(MEMB, 8'h00, 0);
    check_segment("fullmem");

    // Zero-length frame
    bq = '{MG, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes();
    check_segment("zerolen");

    // Garbage in idle-like state, then a one-byte frame
    do_reset_inline();
    bq = '{8'h00, 8'hFF, 8'h12, MG, 8'h01, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F};
    send_bytes();
    check_segment("garbage");

    // Restart from DONE drops the CPU reset on the next cycle
    drive(MG);
    chk("restart.cpu_reset_n", 96'(cpu_reset_n), 96'(0));
    chk("restart.load_done",   96'(load_done),   96'(0));
    bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A};
    send_bytes();
    check_segment("restart");

    // Timeout boundary inside DATA: 16 idle cycles fails, 15 completes
    bq = '{MG, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    send_bytes();
    idle(TO);
    bq = '{8'h03, 8'h04, 8'h0A};
    send_bytes();
    check_segment("gap16");
    bq = '{MG, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    send_bytes();
    idle(TO - 1);
    bq = '{8'h03, 8'h04, 8'h0A};
    send_bytes();
    check_segment("gap15");

    // Reset mid-DATA with a byte in flight: the strobe must be dropped
    bq = '{MG, 8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send_bytes();
    reset_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h44;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rx_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    sent.delete(); obs.delete(); m_done = 1'b0; m_err = 1'b0;
    bq = '{MG, 8'h03, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hDE, 8'h01, 8'h9F};
    send_bytes();
    check_segment("afterreset");

    // Random frames with random gaps, garbage and corrupted checksums
    for (int f = 0; f < 30; f++) begin
      int len;
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == MG) g = 8'h00;
        drive(g);
      end
      len = $urandom_range(0, 8);
      pay.delete();
      for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
      send_frame(len,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 ($urandom_range(0, 7) == 0) ? TO + 1 : 2);
      check_segment("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic do_reset_inline();
    reset_n = 1'b0;
    rx_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_outputs("reset2");
    reset_n = 1'b1;
    @(posedge clk); #1;
    sent.delete(); obs.delete(); m_done = 1'b0; m_err = 1'b0;
  endtask
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader; the initiating side of the CPU top's program-memory byte-write port (write_address/write_data/write_enable).
- Receives a framed program image over a valid/ready byte channel, for example from a UART receiver, and issues one program-memory byte write per payload byte.
- Holds the CPU in reset while loading and releases it once a frame is complete and its checksum matches.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first payload byte.
- MEM_BYTES, 1024, program memory capacity in bytes; a frame with length > MEM_BYTES is rejected.
- TIMEOUT_CYCLES, 100000, maximum idle cycles allowed between bytes inside a frame.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready
- write_address  out  32  program memory byte address
- write_data  out  8  program memory byte
- write_enable  out  1  one-cycle write strobe
- cpu_reset_n  out  1  active-low reset driven to the CPU
- load_done  out  1  a valid image is loaded and the CPU is running
- load_error  out  1  the last frame failed

Behaviour:
- Single clock domain. Reset is synchronous and active-low on reset_n.
- Reset values:
  - state = IDLE
  - rx_ready = 0
  - write_address = BASE_ADDR
  - write_data = 0, write_enable = 0
  - cpu_reset_n = 0, load_done = 0, load_error = 0
  - byte counter, length and checksum = 0
- Frame format: MAGIC, then 4 length bytes (N, little-endian), then N payload bytes, then 1 checksum byte. The checksum is the sum of the payload bytes mod 256.
- rx_ready = 1 in every state except the reset cycle, and it is registered. Every accepted byte is consumed in one cycle; there is no backpressure.
- FSM states and transitions:
  - IDLE: non-MAGIC bytes are dropped. MAGIC -> LEN. load_error and load_done are cleared and cpu_reset_n is held at 0.
  - LEN: accept 4 bytes, LSB first, into length.
    - After the 4th byte: N > MEM_BYTES -> ERROR; N == 0 -> CHK; otherwise -> DATA.
    - Reset checksum = 0 and write_address = BASE_ADDR.
  - DATA: each accepted byte produces write_enable = 1 on the next cycle, with write_data = the byte and write_address = BASE_ADDR + index. That is one cycle of latency from handshake to strobe.
    - The checksum accumulates 8-bit wrap-around.
    - After byte N-1 is accepted -> CHK.
    - Back-to-back bytes produce back-to-back strobes with the address incrementing by 1.
  - CHK: one byte. If it equals the checksum -> DONE, otherwise -> ERROR.
  - DONE: cpu_reset_n = 1 and load_done = 1, both registered on DONE entry. A MAGIC byte restarts the load: cpu_reset_n goes to 0 the cycle after, load_done clears, -> LEN. Non-MAGIC bytes are ignored.
  - ERROR: load_error = 1, cpu_reset_n = 0, no writes. A MAGIC byte -> LEN and clears load_error.
- Timeout: in LEN, DATA and CHK an idle counter increments on every cycle with no transfer and clears on each transfer. Reaching TIMEOUT_CYCLES -> ERROR.
- Writes already issued from a failed frame remain in memory. The CPU stays in reset, so they are harmless.
- write_enable is never asserted outside DATA, except for the final strobe one cycle after the last DATA handshake.
- reset_n low mid-frame aborts immediately: all outputs return to reset values and any pending strobe is dropped.
- Address arithmetic is 32-bit and does not wrap inside MEM_BYTES, because the length check guarantees the frame fits.

Test Plan:
- Reset, then stream A5, 04 00 00 00, 13 00 00 00, 13 -> strobes at addresses 0..3 with data 13, 00, 00, 00 on consecutive cycles. cpu_reset_n = 1 and load_done = 1 two cycles after the checksum handshake.
- Same frame with checksum 14 -> no DONE, load_error = 1, cpu_reset_n stays 0. A following valid frame recovers: load_done = 1, load_error = 0.
- Length 0x00000401 with MEM_BYTES = 1024 -> ERROR right after the 4th length byte, and no write_enable is ever asserted.
- Garbage bytes 00 FF 12 in IDLE, then a valid 1-byte frame A5 01 00 00 00 7F 7F -> garbage is ignored, a single write of 7F at BASE_ADDR, then DONE.
- rx_valid drops for TIMEOUT_CYCLES (set to 16) in the middle of DATA -> ERROR on cycle 16. A gap of 15 cycles completes normally.
- Assert reset_n low for 1 cycle mid-DATA -> outputs return to reset values, and the next frame loads from BASE_ADDR. In DONE, sending A5 drops cpu_reset_n to 0 the next cycle.
